// File: rtl/cdt_irq_ctrl_pkg.sv
// Shared register map, control/status bit layout and reload FSM encodings for cdt_irq_ctrl.
package cdt_irq_ctrl_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RELOAD = 2'd2;
    localparam logic [1:0] REG_EXPCNT = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_AUTO = 2;
    localparam int STAT_PEND = 0;
    localparam int STAT_OVR  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ARM  = 1'b1
    } rl_state_t;

    typedef struct packed {
        logic auto_rl;
        logic ie;
        logic en;
    } ctrl_t;

    typedef struct packed {
        logic ovr;
        logic pend;
    } status_t;

    // we[0] guards the most significant byte, we[3] the least significant one.
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
    endfunction

endpackage

// File: rtl/cdt_expire_detect.sv
// Flags the countdown value falling from nonzero to zero; expire is combinational in the cycle cnt_i reads 0.
// No backpressure: cnt_prev follows cnt_i every cycle, so a count held at zero fires only once.
module cdt_expire_detect (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cnt_i,
    output logic        expire
);

    logic [31:0] cnt_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_prev <= '0;
        else       cnt_prev <= cnt_i;
    end

    assign expire = (cnt_prev != 32'd0) && (cnt_i == 32'd0);

endmodule

// File: rtl/cdt_irq_ctrl.sv
// Timer interrupt/auto-reload controller: registers update on the write edge, irq_o one edge after expiry.
// Zero-wait bus (ready follows sel by one cycle); the reload strobe is held off while the CPU writes the timer.
module cdt_irq_ctrl
    import cdt_irq_ctrl_pkg::*;
#(
    parameter int EXP_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_sel,
    input  logic [1:0]  irq_addr,
    input  logic [31:0] irq_data_i,
    input  logic [3:0]  we,
    output logic        irq_ready,
    output logic [31:0] irq_data_o,
    input  logic [31:0] cnt_i,
    input  logic        timer_wr_i,
    output logic        reload_we,
    output logic [31:0] reload_data,
    output logic        irq_o
);

    ctrl_t      ctrl, ctrl_nxt;
    status_t    status, status_nxt;
    logic [31:0] reload, reload_nxt;
    logic [EXP_W-1:0] expcnt, expcnt_nxt;
    rl_state_t  state;

    logic        expire, exp_en, wr;
    logic [31:0] wmask;

    cdt_expire_detect u_expire (
        .clk    (clk),
        .reset  (reset),
        .cnt_i  (cnt_i),
        .expire (expire)
    );

    assign wr     = irq_sel && (we != 4'b0000);
    assign wmask  = byte_mask(we);
    assign exp_en = expire && ctrl.en;

    always_comb begin
        ctrl_nxt   = ctrl;
        status_nxt = status;
        reload_nxt = reload;
        expcnt_nxt = expcnt;
        if (wr && irq_addr == REG_CTRL) begin
            if (wmask[CTRL_EN])   ctrl_nxt.en      = irq_data_i[CTRL_EN];
            if (wmask[CTRL_IE])   ctrl_nxt.ie      = irq_data_i[CTRL_IE];
            if (wmask[CTRL_AUTO]) ctrl_nxt.auto_rl = irq_data_i[CTRL_AUTO];
        end
        if (wr && irq_addr == REG_STATUS) begin
            if (wmask[STAT_PEND] && irq_data_i[STAT_PEND]) status_nxt.pend = 1'b0;
            if (wmask[STAT_OVR]  && irq_data_i[STAT_OVR])  status_nxt.ovr  = 1'b0;
        end
        // Expiry is applied after the W1C so a same-cycle set wins.
        if (exp_en) begin
            status_nxt.pend = 1'b1;
            if (status.pend) status_nxt.ovr = 1'b1;
        end
        if (wr && irq_addr == REG_RELOAD)
            reload_nxt = (irq_data_i & wmask) | (reload & ~wmask);
        if (wr && irq_addr == REG_EXPCNT)
            expcnt_nxt = '0;
        expcnt_nxt = expcnt_nxt + EXP_W'(exp_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl      <= '0;
            status    <= '0;
            reload    <= '0;
            expcnt    <= '0;
            irq_ready <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            ctrl      <= ctrl_nxt;
            status    <= status_nxt;
            reload    <= reload_nxt;
            expcnt    <= expcnt_nxt;
            irq_ready <= irq_sel;
            irq_o     <= status_nxt.pend && ctrl_nxt.ie;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (exp_en && ctrl.auto_rl && reload != 32'd0) state <= ST_ARM;
                ST_ARM:  if (!ctrl.auto_rl || !timer_wr_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The strobe must land in the same cycle the CPU leaves the timer alone, so it looks at timer_wr_i directly.
    assign reload_we   = (state == ST_ARM) && ctrl.auto_rl && !timer_wr_i;
    assign reload_data = reload;

    always_comb begin
        irq_data_o = 32'd0;
        case (irq_addr)
            REG_CTRL:   irq_data_o = {29'd0, ctrl};
            REG_STATUS: irq_data_o = {30'd0, status};
            REG_RELOAD: irq_data_o = reload;
            REG_EXPCNT: irq_data_o = 32'(expcnt);
            default:    irq_data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cdt_irq_ctrl.sv
// Directed bench for cdt_irq_ctrl with read and reload scoreboards checked by a negedge monitor.
module tb_cdt_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq_sel = 1'b0;
    logic [1:0]  irq_addr = 2'd0;
    logic [31:0] irq_data_i = 32'd0;
    logic [3:0]  we = 4'd0;
    logic        irq_ready;
    logic [31:0] irq_data_o;
    logic [31:0] cnt_i = 32'd0;
    logic        timer_wr_i = 1'b0;
    logic        reload_we;
    logic [31:0] reload_data;
    logic        irq_o;

    cdt_irq_ctrl #(.EXP_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_sel     (irq_sel),
        .irq_addr    (irq_addr),
        .irq_data_i  (irq_data_i),
        .we          (we),
        .irq_ready   (irq_ready),
        .irq_data_o  (irq_data_o),
        .cnt_i       (cnt_i),
        .timer_wr_i  (timer_wr_i),
        .reload_we   (reload_we),
        .reload_data (reload_data),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] rd_q[$];
    string       rd_name[$];
    int          rl_cyc_q[$];
    logic [31:0] rl_dat_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input logic exp_irq,
                            input string nm);
        rd_q.push_back({exp_irq, exp});
        rd_name.push_back(nm);
        irq_sel  = 1'b1;
        irq_addr = a;
        we       = 4'd0;
        tick();
        tick();
        irq_sel = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] w);
        irq_sel    = 1'b1;
        irq_addr   = a;
        irq_data_i = d;
        we         = w;
        tick();
        irq_sel = 1'b0;
        we      = 4'd0;
        tick();
    endtask

    task automatic drop_to_zero;
        cnt_i = 32'd1;
        tick();
        cnt_i = 32'd0;
        tick();
    endtask

    always @(negedge clk) begin : monitor
        logic [32:0] e;
        string       nm;
        int          ec;
        logic [31:0] ed;
        if (irq_ready && irq_sel && we == 4'd0) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: data 0x%08h with no read pending", irq_data_o);
            end else begin
                e  = rd_q.pop_front();
                nm = rd_name.pop_front();
                if (irq_data_o !== e[31:0] || irq_o !== e[32]) begin
                    n_fail++;
                    $display("FAIL %s: got data 0x%08h irq %0b expected data 0x%08h irq %0b",
                             nm, irq_data_o, irq_o, e[31:0], e[32]);
                end
            end
        end
        if (reload_we) begin
            n_tests++;
            if (rl_cyc_q.size() == 0) begin
                n_fail++;
                $display("FAIL reload_unexpected: pulse at cycle %0d data 0x%08h", cyc, reload_data);
            end else begin
                ec = rl_cyc_q.pop_front();
                ed = rl_dat_q.pop_front();
                if (cyc != ec || reload_data !== ed) begin
                    n_fail++;
                    $display("FAIL reload_pulse: got cycle %0d data 0x%08h expected cycle %0d data 0x%08h",
                             cyc, reload_data, ec, ed);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_irq_o", {31'd0, irq_o}, 32'd0);
        check("rst_reload_we", {31'd0, reload_we}, 32'd0);
        check("rst_irq_ready", {31'd0, irq_ready}, 32'd0);
        bus_read(2'd0, 32'h0, 1'b0, "rst_ctrl");
        bus_read(2'd1, 32'h0, 1'b0, "rst_status");
        bus_read(2'd2, 32'h0, 1'b0, "rst_reload");
        bus_read(2'd3, 32'h0, 1'b0, "rst_expcnt");

        // Basic expiry with IE: count 3,2,1,0 then hold at 0.
        bus_write(2'd0, 32'h3, 4'hF);
        cnt_i = 32'd3; tick();
        cnt_i = 32'd2; tick();
        cnt_i = 32'd1; tick();
        cnt_i = 32'd0; tick();
        check("irq_one_edge_after_zero", {31'd0, irq_o}, 32'd1);
        tick(); tick();
        bus_read(2'd1, 32'h1, 1'b1, "status_first_expiry");
        bus_read(2'd3, 32'h1, 1'b1, "expcnt_no_repeat");
        bus_read(2'd0, 32'h3, 1'b1, "ctrl_readback");

        // Second expiry while pending sets OVR.
        drop_to_zero();
        bus_read(2'd1, 32'h3, 1'b1, "status_ovr");
        bus_read(2'd3, 32'h2, 1'b1, "expcnt_two");

        // Third expiry in the same cycle as W1C of PEND: set wins.
        cnt_i = 32'd1; tick();
        cnt_i = 32'd0;
        irq_sel = 1'b1; irq_addr = 2'd1; irq_data_i = 32'h1; we = 4'hF;
        tick();
        irq_sel = 1'b0; we = 4'd0;
        tick();
        bus_read(2'd1, 32'h3, 1'b1, "status_set_wins");
        bus_read(2'd3, 32'h3, 1'b1, "expcnt_three");
        bus_write(2'd1, 32'h3, 4'hF);
        bus_read(2'd1, 32'h0, 1'b0, "status_w1c");

        // IE clear masks irq_o but PEND still latches.
        bus_write(2'd0, 32'h1, 4'hF);
        drop_to_zero();
        bus_read(2'd1, 32'h1, 1'b0, "pend_masked");
        bus_write(2'd0, 32'h3, 4'hF);
        bus_read(2'd1, 32'h1, 1'b1, "pend_unmasked");
        bus_read(2'd3, 32'h4, 1'b1, "expcnt_four");

        // EXPCNT clear together with an expiry leaves 1.
        cnt_i = 32'd1; tick();
        cnt_i = 32'd0;
        irq_sel = 1'b1; irq_addr = 2'd3; irq_data_i = 32'h0; we = 4'hF;
        tick();
        irq_sel = 1'b0; we = 4'd0;
        tick();
        bus_read(2'd3, 32'h1, 1'b1, "expcnt_clear_and_expire");
        bus_write(2'd1, 32'h3, 4'hF);

        // EN=0: expiry ignored entirely.
        bus_write(2'd0, 32'h2, 4'hF);
        drop_to_zero();
        bus_read(2'd1, 32'h0, 1'b0, "en0_status");
        bus_read(2'd3, 32'h1, 1'b0, "en0_expcnt");

        // Auto reload without conflict: pulse the cycle after cnt_i reads 0.
        bus_write(2'd2, 32'h10, 4'hF);
        bus_write(2'd0, 32'h5, 4'hF);
        check("reload_data_drive", reload_data, 32'h10);
        cnt_i = 32'd1; tick();
        cnt_i = 32'd0;
        rl_cyc_q.push_back(cyc + 1); rl_dat_q.push_back(32'h10);
        tick(); tick(); tick();
        bus_read(2'd1, 32'h1, 1'b0, "auto_pend");

        // Timer write held for 3 cycles from the expiry defers the pulse.
        cnt_i = 32'd1; tick();
        cnt_i = 32'd0; timer_wr_i = 1'b1;
        rl_cyc_q.push_back(cyc + 3); rl_dat_q.push_back(32'h10);
        tick(); tick(); tick();
        timer_wr_i = 1'b0;
        tick(); tick();

        // Clearing AUTO while armed aborts the reload.
        cnt_i = 32'd1; tick();
        cnt_i = 32'd0; timer_wr_i = 1'b1;
        tick();
        irq_sel = 1'b1; irq_addr = 2'd0; irq_data_i = 32'h1; we = 4'hF;
        tick();
        irq_sel = 1'b0; we = 4'd0; timer_wr_i = 1'b0;
        tick(); tick();

        // Byte-lane writes to RELOAD.
        bus_write(2'd2, 32'h0, 4'hF);
        bus_write(2'd2, 32'hAABBCCDD, 4'b0001);
        bus_read(2'd2, 32'hAA000000, 1'b0, "reload_byte_msb");
        bus_write(2'd2, 32'h11223344, 4'b0110);
        bus_read(2'd2, 32'hAA223300, 1'b0, "reload_byte_mid");

        // Reset asserted while armed: no strobe, irq_o drops at once.
        bus_write(2'd1, 32'h3, 4'hF);
        bus_write(2'd0, 32'h7, 4'hF);
        cnt_i = 32'd1; tick();
        cnt_i = 32'd0; timer_wr_i = 1'b1;
        tick();
        check("armed_irq_o", {31'd0, irq_o}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_irq_o", {31'd0, irq_o}, 32'd0);
        check("async_rst_reload_we", {31'd0, reload_we}, 32'd0);
        timer_wr_i = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        bus_read(2'd0, 32'h0, 1'b0, "post_rst_ctrl");
        bus_read(2'd1, 32'h0, 1'b0, "post_rst_status");
        bus_read(2'd2, 32'h0, 1'b0, "post_rst_reload");
        bus_read(2'd3, 32'h0, 1'b0, "post_rst_expcnt");
        tick(); tick();

        check("reads_left", rd_q.size(), 32'd0);
        check("reloads_left", rl_cyc_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdt_irq_ctrl.md
Name: cdt_irq_ctrl

Overview:
- Memory-mapped companion to the countdown timer; sits directly downstream of it and consumes its 32-bit count value.
- Detects timer expiry, which is the count transitioning from nonzero to zero.
- On expiry it latches a sticky interrupt-pending flag, drives a level IRQ to the CPU, counts expiries, and can optionally auto-reload the timer.
- Attaches to the same CPU peripheral bus as the timer: sel / we / data plus one-cycle ready.

Parameters:
- EXP_W, 16: width of the expiry counter (EXPCNT register); wraps modulo 2^EXP_W.

Ports:
- clk  in  1  system clock
- reset  in  1  one clock; reset is asynchronous and active-high
- irq_sel  in  1  bus select for this block
- irq_addr  in  2  register index (word select)
- irq_data_i  in  32  bus write data
- we  in  4  byte write enables; we[0]->[31:24], we[1]->[23:16], we[2]->[15:8], we[3]->[7:0]; all zero = read
- irq_ready  out  1  bus ready
- irq_data_o  out  32  read data
- cnt_i  in  32  current countdown timer value
- timer_wr_i  in  1  CPU is writing the timer this cycle (timer sel & |we)
- reload_we  out  1  one-cycle strobe: load reload_data into the timer
- reload_data  out  32  reload value to the timer
- irq_o  out  1  level interrupt to CPU

Behaviour:
- Reset values: all registers 0, cnt_prev=0, irq_ready=0, reload_we=0, irq_o=0.
- irq_data_o is a combinational mux of the register selected by irq_addr. Unused bits read 0.
- Register map:
  - 0 CTRL: bit0 EN (latch expiries), bit1 IE (irq enable), bit2 AUTO (auto-reload).
  - 1 STATUS: bit0 PEND, bit1 OVR. Both are write-1-to-clear.
  - 2 RELOAD: 32-bit value, byte-writable.
  - 3 EXPCNT: EXP_W bits, read-only; any write with we!=0 clears it.
- Bus handshake:
  - irq_ready <= irq_sel each cycle. It is high in the cycle after irq_sel is first sampled and low one cycle after irq_sel drops.
  - Writes take effect at the first clock edge where irq_sel & |we.
  - Writes repeat harmlessly while sel is held, except that W1C of a bit set in between also clears it.
- Expiry detection:
  - cnt_prev <= cnt_i every cycle.
  - expire = (cnt_prev != 0) && (cnt_i == 0), evaluated combinationally.
  - cnt_i holding at 0 gives no repeat events.
- On expire with EN=1:
  - PEND <= 1. If PEND was already 1, OVR <= 1.
  - EXPCNT <= EXPCNT + 1, wrapping.
- With EN=0, expiries are ignored entirely: no PEND, OVR, EXPCNT change or reload.
- Simultaneous events: expire and a STATUS W1C in the same cycle leaves the bit set (set wins). Expire and an EXPCNT clear gives EXPCNT = 1.
- irq_o = PEND & IE, registered outputs only. Clearing IE masks irq_o without clearing PEND.
- Reload FSM:
  - IDLE: go to ARM on expire & EN & AUTO & RELOAD != 0.
  - ARM:
    - If timer_wr_i=0: assert reload_we for exactly this cycle, with reload_data = RELOAD, then go to IDLE.
    - If timer_wr_i=1: hold in ARM with reload_we=0. CPU timer writes win and the reload is deferred, not dropped.
  - Net latency: expire seen at edge N, reload_we high during cycle N+1 (no conflict).
  - reload_data always drives RELOAD.
  - Clearing AUTO while in ARM aborts the reload: return to IDLE, no strobe.
- Reset mid-operation clears the FSM to IDLE, drops reload_we and irq_o immediately (async), and clears all registers.

Decomposition:
- Shared package holds the register indices (CTRL=0, STATUS=1, RELOAD=2, EXPCNT=3), CTRL/STATUS bit positions, and reload FSM state encodings (IDLE, ARM).
- One natural sub-module: cdt_expire_detect (cnt_prev register + nonzero-to-zero edge).
- Bus regs and FSM stay in the top.

Test Plan:
- Reset, then read all four addresses -> each reads 0x00000000; irq_o=0, reload_we=0.
- CTRL=0x3; drive cnt_i 3,2,1,0,0 -> PEND=1 one edge after cnt_i=0, irq_o=1, EXPCNT=1, no second event while cnt_i holds 0.
- PEND set; second 1->0 transition -> STATUS reads 0x3. Write STATUS 0x1 in the same cycle as a third expiry -> PEND stays 1.
- CTRL=0x5, RELOAD=0x00000010, expiry -> reload_we high exactly 1 cycle, the cycle after cnt_i=0, with reload_data=0x10.
- Same as above but timer_wr_i=1 for 3 cycles starting at the expiry -> reload_we deferred until the first cycle timer_wr_i=0, then a single pulse.
- Byte write to RELOAD with we=4'b0001, data 0xAABBCCDD -> RELOAD reads 0xAA000000. Assert reset while in ARM -> reload_we never pulses.
